// File: rtl/cdb_pkg.sv
// Shared constants for the Common Data Bus: widths, requester count and RS tag names.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cdb_pkg;

  // Number of functional units sharing the bus: 0=add/sub RS, 1=mult RS, 2=load
  localparam int N_REQ  = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  // Tag 0 means "no producer" and must never be broadcast
  localparam logic [TAG_W-1:0] TAG_NONE = 3'b000;
  localparam logic [TAG_W-1:0] RS1      = 3'b001;
  localparam logic [TAG_W-1:0] RS2      = 3'b010;
  localparam logic [TAG_W-1:0] RS3      = 3'b011;

  // Width of an index into n requesters (at least one bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; callers mask req to suppress a grant.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters starting at ptr and take the first one that is set
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers one result per functional unit and broadcasts them round-robin on the CDB.
// Latency: result accepted at edge E is on the CDB in the cycle after edge E+1 (uncontended).
// Backpressure: req_ready drops while a unit's slot is full and not granted; cdb_stall freezes slots and ptr.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      cdb_stall,
  output logic                      teveEscritaCDB,
  output logic [TAG_W-1:0]          nameCDB,
  output logic [DATA_W-1:0]         dadoCDB,
  output logic [1:0]                grant_id,
  output logic                      err_tag0
);

  localparam int PW = ptr_width(N_REQ);

  logic [N_REQ-1:0]  slot_valid;
  logic [TAG_W-1:0]  slot_tag  [N_REQ];
  logic [DATA_W-1:0] slot_data [N_REQ];
  logic [PW-1:0]     ptr;

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     grant_idx;
  logic              any_grant;
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  tag_zero;
  logic              tag0_seen;

  // Arbitration only sees registered slots; a stall removes every candidate
  assign arb_req   = cdb_stall ? '0 : slot_valid;
  assign any_grant = |grant;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A slot being granted this cycle can be refilled in the same cycle
  assign req_ready = reset_n ? (~slot_valid | grant) : '0;

  // Decode handshakes and flag offers carrying the "no producer" tag
  always_comb begin
    tag_zero = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tag_zero[i] = (req_tag[i*TAG_W +: TAG_W] == TAG_NONE);
    end
    accept    = req_valid & req_ready;
    tag0_seen = |(accept & tag_zero);
  end

  // Holding slots: capture on accept (tag 0 dropped), release when broadcast
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i] && !tag_zero[i]) begin
          slot_valid[i] <= 1'b1;
          slot_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
          slot_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Registered broadcast and round-robin pointer advance past the winner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      teveEscritaCDB <= 1'b0;
      nameCDB        <= '0;
      dadoCDB        <= '0;
      grant_id       <= '0;
      ptr            <= '0;
    end else begin
      teveEscritaCDB <= any_grant;
      if (any_grant) begin
        nameCDB  <= slot_tag[grant_idx];
        dadoCDB  <= slot_data[grant_idx];
        grant_id <= 2'(grant_idx);
        ptr      <= (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Sticky error: some unit handed over a result with tag 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_tag0 <= 1'b0;
    end else if (tag0_seen) begin
      err_tag0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-unit scoreboard of accepted results.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: results are pushed only when req_valid & req_ready at the edge.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    cdb_stall;
  logic                    teveEscritaCDB;
  logic [TAG_W-1:0]        nameCDB;
  logic [DATA_W-1:0]       dadoCDB;
  logic [1:0]              grant_id;
  logic                    err_tag0;

  typedef struct {
    int          unit;
    logic [2:0]  tag;
    logic [15:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          log_q[$];
  logic [2:0]  fire;
  int          checks = 0;
  int          errors = 0;

  cdb_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tag        (req_tag),
    .req_data       (req_data),
    .cdb_stall      (cdb_stall),
    .teveEscritaCDB (teveEscritaCDB),
    .nameCDB        (nameCDB),
    .dadoCDB        (dadoCDB),
    .grant_id       (grant_id),
    .err_tag0       (err_tag0)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int u, input logic [2:0] t, input logic [15:0] d);
    req_valid[u]           = 1'b1;
    req_tag[u*3 +: 3]      = t;
    req_data[u*16 +: 16]   = d;
  endtask

  // One clock: record handshakes before the edge, check any broadcast after it
  task automatic tick();
    exp_t e;
    int   g;
    int   idx;
    @(negedge clock);
    fire = req_valid & req_ready;
    for (int i = 0; i < 3; i++) begin
      if (fire[i] && reset_n && req_tag[i*3 +: 3] != TAG_NONE) begin
        e.unit = i;
        e.tag  = req_tag[i*3 +: 3];
        e.data = req_data[i*16 +: 16];
        sbq.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    if (teveEscritaCDB === 1'b1) begin
      g   = int'(grant_id);
      idx = -1;
      for (int k = 0; k < sbq.size(); k++) begin
        if (idx < 0 && sbq[k].unit == g) idx = k;
      end
      chk("sb_expected", (idx >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (idx >= 0) begin
        chk("sb_tag", 32'(nameCDB), 32'(sbq[idx].tag));
        chk("sb_data", 32'(dadoCDB), 32'(sbq[idx].data));
        sbq.delete(idx);
      end
      log_q.push_back(g);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  int pos2;
  int cnt0;
  int cnt2;
  int fires0;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    cdb_stall = 1'b0;

    // Power-on reset
    tick();
    tick();
    chk("rst_vld", 32'(teveEscritaCDB), 32'd0);
    chk("rst_name", 32'(nameCDB), 32'd0);
    chk("rst_dado", 32'(dadoCDB), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(err_tag0), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd7);

    // Single result from unit1: on the bus exactly in the cycle after E+1
    set_req(1, RS2, 16'h1234);
    tick();
    req_valid = '0;
    chk("single_e0", 32'(teveEscritaCDB), 32'd0);
    tick();
    chk("single_vld", 32'(teveEscritaCDB), 32'd1);
    chk("single_name", 32'(nameCDB), 32'd2);
    chk("single_dado", 32'(dadoCDB), 32'h1234);
    chk("single_gid", 32'(grant_id), 32'd1);
    tick();
    chk("single_end", 32'(teveEscritaCDB), 32'd0);
    chk("single_hold", 32'(dadoCDB), 32'h1234);

    // Unit2 alone moves ptr back to 0
    set_req(2, RS3, 16'h0003);
    tick();
    req_valid = '0;
    drain(10);

    // Contention: three at once, ptr=0 -> tags 1,2,3 back to back
    set_req(0, RS1, 16'hA001);
    set_req(1, RS2, 16'hA002);
    set_req(2, RS3, 16'hA003);
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("cont_vld", 32'(teveEscritaCDB), 32'd1);
      chk("cont_tag", 32'(nameCDB), 32'(k + 1));
    end
    tick();
    chk("cont_idle", 32'(teveEscritaCDB), 32'd0);
    // ptr back at 0: unit0 must win over unit2
    log_q = {};
    set_req(0, RS1, 16'hC000);
    set_req(2, RS3, 16'hC002);
    tick();
    req_valid = '0;
    drain(10);
    chk("ptr_wrap_cnt", 32'(log_q.size()), 32'd2);
    chk("ptr_wrap_first", 32'(log_q[0]), 32'd0);

    // Fairness: unit0 re-requests every cycle, unit2 holds one result
    log_q  = {};
    fires0 = 0;
    set_req(0, RS1, 16'h0100);
    set_req(2, RS3, 16'h0300);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (fire[2]) req_valid[2] = 1'b0;
      if (fire[0]) begin
        fires0++;
        req_data[15:0] = req_data[15:0] + 16'd1;
      end
    end
    req_valid = '0;
    drain(10);
    pos2 = -1;
    cnt0 = 0;
    cnt2 = 0;
    for (int k = 0; k < log_q.size(); k++) begin
      if (log_q[k] == 2) begin
        cnt2++;
        if (pos2 < 0) pos2 = k;
      end
      if (log_q[k] == 0) cnt0++;
    end
    chk("fair_u2_pos", (pos2 >= 0 && pos2 < 2) ? 32'd1 : 32'd0, 32'd1);
    chk("fair_u2_cnt", 32'(cnt2), 32'd1);
    chk("fair_u0_cnt", 32'(cnt0), 32'(fires0));

    // Ptr from 1 to 0 via a lone unit2 result
    set_req(2, RS3, 16'h0333);
    tick();
    req_valid = '0;
    drain(10);

    // Stall with two full slots, then release: order 0 then 1
    cdb_stall = 1'b1;
    set_req(0, RS1, 16'hB001);
    set_req(1, RS2, 16'hB002);
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_vld", 32'(teveEscritaCDB), 32'd0);
      chk("stall_rdy_full", 32'(req_ready[1:0]), 32'd0);
      chk("stall_rdy_free", 32'(req_ready[2]), 32'd1);
    end
    cdb_stall = 1'b0;
    tick();
    chk("stall_r0_vld", 32'(teveEscritaCDB), 32'd1);
    chk("stall_r0_gid", 32'(grant_id), 32'd0);
    tick();
    chk("stall_r1_vld", 32'(teveEscritaCDB), 32'd1);
    chk("stall_r1_gid", 32'(grant_id), 32'd1);

    // Stall in the middle of a burst from ptr=2: order 2, pause, 0, 1
    set_req(0, RS1, 16'hD001);
    set_req(1, RS2, 16'hD002);
    set_req(2, RS3, 16'hD003);
    tick();
    req_valid = '0;
    tick();
    chk("burst_first", 32'(grant_id), 32'd2);
    cdb_stall = 1'b1;
    tick();
    chk("burst_pause", 32'(teveEscritaCDB), 32'd0);
    tick();
    chk("burst_pause", 32'(teveEscritaCDB), 32'd0);
    cdb_stall = 1'b0;
    tick();
    chk("burst_resume0", 32'(grant_id), 32'd0);
    tick();
    chk("burst_resume1", 32'(grant_id), 32'd1);
    chk("burst_resume_vld", 32'(teveEscritaCDB), 32'd1);

    // Tag 0 offer: dropped, sticky error, ready stays high
    set_req(2, TAG_NONE, 16'hFFFF);
    tick();
    req_valid = '0;
    chk("tag0_err", 32'(err_tag0), 32'd1);
    chk("tag0_ready", 32'(req_ready[2]), 32'd1);
    tick();
    chk("tag0_nobcast", 32'(teveEscritaCDB), 32'd0);
    tick();
    chk("tag0_nobcast", 32'(teveEscritaCDB), 32'd0);
    chk("tag0_sticky", 32'(err_tag0), 32'd1);

    // Reset in the middle of a burst discards everything
    set_req(0, RS1, 16'hE001);
    set_req(1, RS2, 16'hE002);
    set_req(2, RS3, 16'hE003);
    tick();
    req_valid = '0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(teveEscritaCDB), 32'd0);
    chk("mrst_name", 32'(nameCDB), 32'd0);
    chk("mrst_dado", 32'(dadoCDB), 32'd0);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_err", 32'(err_tag0), 32'd0);
    chk("mrst_ready", 32'(req_ready), 32'd0);
    sbq = {};
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("mrst_rel_ready", 32'(req_ready), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_stale", 32'(teveEscritaCDB), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
